// File: rtl/program_counter.sv
// program_counter
//   RV32 fetch-stage program counter. Holds the current instruction address
//   and selects the next one each cycle: sequential step, PC-relative jump by
//   an immediate offset, or an absolute ALU-computed target (JALR).
//
// Ports
//   clk              in   1     rising-edge clock
//   reset_n          in   1     asynchronous active-low reset
//   alu_imm_pc_next  in   XLEN  absolute next-PC target from the ALU (rs1+imm)
//   imm_offset       in   XLEN  PC-relative offset, sign-extended upstream
//   pc_alu_sel       in   1     adder operand: 0 = PC_STEP, 1 = imm_offset
//   pc_next_sel      in   1     next PC: 0 = adder result, 1 = alu_imm_pc_next
//   pc_value         out  XLEN  current PC (registered)
//   pc_alu           out  XLEN  pc_value + selected operand (combinational)
module program_counter #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] PC_STEP      = XLEN'(4)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] alu_imm_pc_next,
    input  logic [XLEN-1:0] imm_offset,
    input  logic            pc_alu_sel,
    input  logic            pc_next_sel,
    output logic [XLEN-1:0] pc_value,
    output logic [XLEN-1:0] pc_alu
);

    logic [XLEN-1:0] adder_operand;
    logic [XLEN-1:0] pc_next;

    // The adder result wraps modulo 2^XLEN; no overflow is reported.
    always_comb begin
        adder_operand = pc_alu_sel ? imm_offset : PC_STEP;
        pc_alu        = pc_value + adder_operand;
    end

    // The ALU target always has bit 0 cleared (JALR semantics); adder
    // results are taken as-is, so a misaligned offset is not trapped here.
    always_comb begin
        pc_next = pc_alu;
        if (pc_next_sel) begin
            pc_next = {alu_imm_pc_next[XLEN-1:1], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_value <= RESET_VECTOR;
        end else begin
            pc_value <= pc_next;
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter
//   Self-checking bench for program_counter: directed scenarios for reset,
//   sequential stepping, ALU loads, PC-relative jumps (forward and backward),
//   wrap-around and load priority, followed by randomized cycles with
//   occasional mid-cycle resets, all checked against a reference model.
module tb_program_counter;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic [31:0] alu_imm_pc_next;
    logic [31:0] imm_offset;
    logic        pc_alu_sel;
    logic        pc_next_sel;
    logic [31:0] pc_value;
    logic [31:0] pc_alu;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state: the architectural PC the DUT should hold.
    logic [31:0] model_pc;

    program_counter #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_0000),
        .PC_STEP     (32'd4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .alu_imm_pc_next(alu_imm_pc_next),
        .imm_offset     (imm_offset),
        .pc_alu_sel     (pc_alu_sel),
        .pc_next_sel    (pc_next_sel),
        .pc_value       (pc_value),
        .pc_alu         (pc_alu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Adder result as RV32 defines it: 32-bit two's complement sum.
    function automatic logic [31:0] ref_adder(input logic [31:0] pc, input logic use_imm,
                                              input logic [31:0] imm);
        longint unsigned sum;
        sum = longint'(pc) + (use_imm ? longint'(imm) : 64'd4);
        return 32'(sum % 64'h1_0000_0000);
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic use_alu,
                                             input logic use_imm, input logic [31:0] imm,
                                             input logic [31:0] target);
        if (use_alu) return (target / 2) * 2;
        return ref_adder(pc, use_imm, imm);
    endfunction

    // Called at a falling edge: drive, check combinational adder, take one
    // rising edge, check the registered PC, return at the next falling edge.
    task automatic step(input string tag, input logic nsel, input logic asel,
                        input logic [31:0] target, input logic [31:0] imm);
        pc_next_sel     = nsel;
        pc_alu_sel      = asel;
        alu_imm_pc_next = target;
        imm_offset      = imm;
        #1;
        check_eq({tag, ".pc_alu"}, pc_alu, ref_adder(model_pc, asel, imm));
        @(posedge clk);
        #1;
        model_pc = ref_next(model_pc, nsel, asel, imm, target);
        check_eq({tag, ".pc_value"}, pc_value, model_pc);
        @(negedge clk);
    endtask

    // Called at a falling edge: assert reset between edges, confirm the PC
    // clears at once and holds across an edge, release at the next fall.
    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_pc = RESET_PC;
        check_eq({tag, ".async"}, pc_value, model_pc);
        @(posedge clk);
        #1;
        check_eq({tag, ".held"}, pc_value, model_pc);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] tgt;
        logic [31:0] imm;
        logic        ns;
        logic        as;

        // 1. Reset from t=0, release at t=10, ten sequential steps.
        reset_n         = 1'b0;
        pc_next_sel     = 1'b0;
        pc_alu_sel      = 1'b0;
        alu_imm_pc_next = '0;
        imm_offset      = '0;
        model_pc        = RESET_PC;
        #2;
        check_eq("reset.pc_value", pc_value, 32'h0);
        check_eq("reset.pc_alu", pc_alu, 32'h4);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step("seq", 1'b0, 1'b0, $urandom, $urandom);
        check_eq("seq.after10", pc_value, 32'h28);

        // 4. Forward PC-relative jumps by 400 from 0x28.
        pc_alu_sel = 1'b1;
        imm_offset = 32'h190;
        #1;
        check_eq("rel.comb", pc_alu, 32'h1B8);
        for (int i = 0; i < 4; i++) step("rel", 1'b0, 1'b1, $urandom, 32'h190);
        check_eq("rel.after4", pc_value, 32'h668);

        // 2. Absolute ALU load then a sequential step.
        step("load", 1'b1, 1'b0, 32'hFF00FF00, $urandom);
        check_eq("load.value", pc_value, 32'hFF00FF00);
        step("load.seq", 1'b0, 1'b0, $urandom, $urandom);
        check_eq("load.seq.value", pc_value, 32'hFF00FF04);

        // 3. Reset between edges, then sequential from the reset vector.
        pulse_reset("midreset");
        step("post.reset0", 1'b0, 1'b0, $urandom, $urandom);
        check_eq("post.reset.first", pc_value, 32'h4);
        step("post.reset1", 1'b0, 1'b0, $urandom, $urandom);

        // 5. Backward steps by -8 from 0x20, then wrap from 0xFFFFFFFC.
        for (int i = 0; i < 6; i++) step("to20", 1'b0, 1'b0, $urandom, $urandom);
        check_eq("at20", pc_value, 32'h20);
        step("back0", 1'b0, 1'b1, $urandom, 32'hFFFFFFF8);
        step("back1", 1'b0, 1'b1, $urandom, 32'hFFFFFFF8);
        check_eq("back.value", pc_value, 32'h10);
        step("to.top", 1'b1, 1'b0, 32'hFFFFFFFD, $urandom);
        check_eq("top.value", pc_value, 32'hFFFFFFFC);
        step("wrap", 1'b0, 1'b0, $urandom, $urandom);
        check_eq("wrap.value", pc_value, 32'h0);

        // 6. Both selects high: ALU target wins with bit 0 cleared.
        step("prio", 1'b1, 1'b1, 32'h00001001, 32'h10);
        check_eq("prio.value", pc_value, 32'h00001000);

        // Misaligned adder result is loaded unchanged.
        step("misalign", 1'b0, 1'b1, $urandom, 32'h3);
        check_eq("misalign.value", pc_value, 32'h00001003);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                pulse_reset("rnd.reset");
            end else begin
                ns  = 1'($urandom_range(0, 1));
                as  = 1'($urandom_range(0, 1));
                tgt = $urandom;
                imm = $urandom;
                if ($urandom_range(0, 3) == 0) imm = -32'($urandom_range(0, 64));
                step("rnd", ns, as, tgt, imm);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
